// File: rtl/contador_cmd_seq.sv
// contador_cmd_seq: queues {modo, d, len} commands and plays each one as LEN enabled counter cycles.
// Optional RCO_STOP_EN: RCO sampled high in RUN ends the command early and pulses ABORT with DONE.
module contador_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_modo,
  input  logic [WIDTH-1:0] cmd_d,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             enb,
  output logic [1:0]       modo,
  output logic [WIDTH-1:0] d,
  input  logic             rco,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;
  state_t           state;
  logic [CNT_W-1:0] rem;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == LOAD);
  assign head = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{cmd_modo, cmd_d, cmd_len};
  end

  // cmd_ready is a registered !full: a pop in the same cycle never frees a slot early
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      cmd_ready <= (count_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
      rem   <= '0;
      enb   <= 1'b0;
      modo  <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      abort <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      busy  <= (state != IDLE) || (count != '0);
      case (state)
        IDLE: begin
          if (count != '0) state <= LOAD;
        end
        LOAD: begin
          rem <= head.len;
          // a zero-length command leaves MODO/D untouched since ENB never rises
          if (head.len == '0) begin
            done  <= 1'b1;
            state <= (count > CNT_ONE) ? LOAD : IDLE;
          end else begin
            enb   <= 1'b1;
            modo  <= head.modo;
            d     <= head.d;
            state <= RUN;
          end
        end
        RUN: begin
          rem <= rem - REM_ONE;
          if (rem == REM_ONE) begin
            enb   <= 1'b0;
            done  <= 1'b1;
            state <= (count != '0) ? LOAD : IDLE;
          end
`ifdef RCO_STOP_EN
          else if (rco) begin
            enb   <= 1'b0;
            done  <= 1'b1;
            abort <= 1'b1;
            state <= (count != '0) ? LOAD : IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RCO_STOP_EN
  logic unused_rco;
  assign unused_rco = rco;
`endif

endmodule

// File: tb/tb_contador_cmd_seq.sv
// Self-checking bench for contador_cmd_seq: directed vectors, corner sequences and a
// randomized run scored against a command-queue model.
module tb_contador_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_modo;
  logic [3:0] cmd_d;
  logic [7:0] cmd_len;
  logic       enb;
  logic [1:0] modo;
  logic [3:0] d;
  logic       rco;
  logic       busy;
  logic       done;
  logic       abort;

  contador_cmd_seq #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_l(rst_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_modo(cmd_modo), .cmd_d(cmd_d), .cmd_len(cmd_len), .enb(enb),
    .modo(modo), .d(d), .rco(rco), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

`ifdef RCO_STOP_EN
  localparam int T6_ENB = 4;
  localparam int T6_ABORT = 1;
`else
  localparam int T6_ENB = 20;
  localparam int T6_ABORT = 0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle trace captured at negedges, plus a summary of it.
  logic       tr_enb [512];
  logic       tr_done [512];
  logic       tr_abort [512];
  logic       tr_busy [512];
  logic [1:0] tr_modo [512];
  logic [3:0] tr_d [512];
  int nruns, n_enb, n_done, n_abort, first_enb, first_done, hold_bad;
  int run_len [8];
  int run_start [8];
  logic [1:0] run_modo [8];
  logic [3:0] run_d [8];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tr_enb[i] = enb; tr_done[i] = done; tr_abort[i] = abort;
      tr_busy[i] = busy; tr_modo[i] = modo; tr_d[i] = d;
      @(negedge clk);
    end
    nruns = 0; n_enb = 0; n_done = 0; n_abort = 0;
    first_enb = -1; first_done = -1; hold_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tr_enb[i]) begin
        n_enb++;
        if (first_enb < 0) first_enb = i;
        if (i == 0 || !tr_enb[i-1]) begin
          if (nruns < 8) begin
            run_start[nruns] = i; run_len[nruns] = 0;
            run_modo[nruns] = tr_modo[i]; run_d[nruns] = tr_d[i];
          end
          nruns++;
        end else if (tr_d[i] != tr_d[i-1] || tr_modo[i] != tr_modo[i-1]) begin
          hold_bad++;
        end
        if (nruns <= 8) run_len[nruns-1]++;
      end
      if (tr_done[i]) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
      if (tr_abort[i]) n_abort++;
    end
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic push_cmd(input logic [1:0] m, input logic [3:0] dv, input logic [7:0] l);
    int n;
    n = 0;
    cmd_modo = m; cmd_d = dv; cmd_len = l; cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_wait", n < 500, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; rco = 1'b0; rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] modo;
    logic [3:0] d;
    logic [7:0] len;
    int exp_first;
    int exp_enb;
    int exp_done;
  } vec_t;

  typedef struct {
    logic [1:0] modo;
    logic [3:0] d;
    int len;
  } model_cmd_t;

  localparam int NV = 5;
  localparam int NR = 150;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [NV];
    model_cmd_t exp_q [$];
    model_cmd_t pend, got;
    int acc, started, tot_enb, ndone, idx, nabort, nboth, gap;
    int pushed, have, in_run, rl, dones, aborts, idle_streak, drained;
    logic [1:0] rm, lm;
    logic [3:0] rd, ld;
    logic prev_enb;

    vt[0] = '{2'b11, 4'hA, 8'd1,   2, 1,   3};
    vt[1] = '{2'b00, 4'h5, 8'd5,   2, 5,   7};
    vt[2] = '{2'b10, 4'hF, 8'd0,  -1, 0,   2};
    vt[3] = '{2'b01, 4'h3, 8'd255, 2, 255, 257};
    vt[4] = '{2'b11, 4'h0, 8'd2,   2, 2,   4};

    rst_l = 1'b0; cmd_valid = 1'b0; rco = 1'b0;
    cmd_modo = '0; cmd_d = '0; cmd_len = '0;

    // Reset values and release
    @(negedge clk);
    check("rst_enb", enb, 0);
    check("rst_modo", modo, 0);
    check("rst_d", d, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort, 0);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    check("release_ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    check("release_ready_after_edge", cmd_ready, 1);
    check("release_busy", busy, 0);

    // Single commands from idle
    for (int v = 0; v < NV; v++) begin
      push_cmd(vt[v].modo, vt[v].d, vt[v].len);
      capture(int'(vt[v].len) + 6);
      check($sformatf("vec%0d_first_enb", v), first_enb, vt[v].exp_first);
      check($sformatf("vec%0d_enb_cycles", v), n_enb, vt[v].exp_enb);
      check($sformatf("vec%0d_done_at", v), first_done, vt[v].exp_done);
      check($sformatf("vec%0d_done_cnt", v), n_done, 1);
      check($sformatf("vec%0d_abort_cnt", v), n_abort, 0);
      check($sformatf("vec%0d_hold", v), hold_bad, 0);
      if (nruns > 0) begin
        check($sformatf("vec%0d_modo", v), run_modo[0], vt[v].modo);
        check($sformatf("vec%0d_d", v), run_d[0], vt[v].d);
      end
      if (first_done >= 0) begin
        check($sformatf("vec%0d_busy_at_done", v), tr_busy[first_done], 1);
        check($sformatf("vec%0d_busy_after_done", v), tr_busy[first_done+1], 0);
      end
    end

    // Queued sequence with a zero-length tail
    push_cmd(2'b00, 4'h1, 8'd5);
    push_cmd(2'b01, 4'h2, 8'd3);
    push_cmd(2'b10, 4'h3, 8'd0);
    capture(25);
    check("seq_runs", nruns, 2);
    check("seq_enb_total", n_enb, 8);
    check("seq_done_cnt", n_done, 3);
    if (nruns >= 2) begin
      gap = run_start[1] - (run_start[0] + run_len[0]);
      check("seq_run0_len", run_len[0], 5);
      check("seq_run1_len", run_len[1], 3);
      check("seq_gap", gap, 1);
      check("seq_run0_modo", run_modo[0], 2'b00);
      check("seq_run1_modo", run_modo[1], 2'b01);
    end

    // FIFO full with valid held high; ready tracks occupancy = accepted - started
    do_reset();
    acc = 0; started = 0; tot_enb = 0; ndone = 0; idx = 0; prev_enb = 1'b0;
    for (int cyc = 0; cyc < 400 && ndone < 7; cyc++) begin
      if (enb && !prev_enb) begin
        started++;
        check("full_order_d", d, started - 1);
      end
      prev_enb = enb;
      if (enb) tot_enb++;
      if (done) ndone++;
      check("full_ready", cmd_ready, (acc - started) < 4);
      if (idx < 7) begin
        cmd_valid = 1'b1; cmd_modo = 2'(idx % 4); cmd_d = 4'(idx); cmd_len = 8'd10;
        if (cmd_ready) begin
          acc++;
          idx++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("full_accepted", acc, 7);
    check("full_started", started, 7);
    check("full_done_cnt", ndone, 7);
    check("full_enb_total", tot_enb, 70);

    // Reset during the 3rd ENB cycle with two commands queued
    push_cmd(2'b00, 4'h1, 8'd8);
    push_cmd(2'b01, 4'h2, 8'd4);
    push_cmd(2'b10, 4'h3, 8'd4);
    n_enb = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (enb) n_enb++;
      if (n_enb == 3) break;
      @(negedge clk);
    end
    check("midrst_reached_3rd", n_enb, 3);
    rst_l = 1'b0;
    #1;
    check("midrst_enb", enb, 0);
    check("midrst_ready", cmd_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_modo_d", {modo, d}, 6'd0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", cmd_ready, 1);
    capture(30);
    check("midrst_no_enb", n_enb, 0);
    check("midrst_no_done", n_done, 0);
    check("midrst_busy_after", tr_busy[29], 0);

    // RCO on the 4th ENB cycle of a LEN=20 command
    push_cmd(2'b01, 4'h4, 8'd20);
    n_enb = 0; ndone = 0; nabort = 0; nboth = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rco = 1'b0;
      if (done) ndone++;
      if (abort) nabort++;
      if (done && abort) nboth++;
      if (enb) begin
        n_enb++;
        if (n_enb == 4) rco = 1'b1;
      end
      @(negedge clk);
    end
    rco = 1'b0;
    check("rco_enb_cycles", n_enb, T6_ENB);
    check("rco_done_cnt", ndone, 1);
    check("rco_abort_cnt", nabort, T6_ABORT);
    check("rco_abort_with_done", nboth, T6_ABORT);

    // RCO on the natural last cycle is a normal completion
    push_cmd(2'b10, 4'h5, 8'd3);
    n_enb = 0; ndone = 0; nabort = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      rco = 1'b0;
      if (done) ndone++;
      if (abort) nabort++;
      if (enb) begin
        n_enb++;
        if (n_enb == 3) rco = 1'b1;
      end
      @(negedge clk);
    end
    rco = 1'b0;
    check("rco_last_enb_cycles", n_enb, 3);
    check("rco_last_done_cnt", ndone, 1);
    check("rco_last_abort_cnt", nabort, 0);

    // Randomized traffic scored against an in-order command queue
    do_reset();
    pushed = 0; have = 0; in_run = 0; rl = 0; dones = 0; aborts = 0;
    idle_streak = 0; drained = 0;
    lm = '0; ld = '0; rm = '0; rd = '0;
    pend = '{2'b00, 4'h0, 0};
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (enb) begin
        if (!in_run) begin
          in_run = 1; rl = 0; rm = modo; rd = d;
        end else begin
          check("rnd_run_stable", {modo, d}, {rm, rd});
        end
        rl++;
        lm = modo; ld = d;
      end else begin
        check("rnd_idle_hold", {modo, d}, {lm, ld});
        if (in_run) begin
          in_run = 0;
          check("rnd_run_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            check("rnd_run_len", rl, got.len);
            check("rnd_run_modo", rm, got.modo);
            check("rnd_run_d", rd, got.d);
          end
        end
      end
      if (done) dones++;
      if (abort) aborts++;

      if (!enb && !busy && !cmd_valid && have == 0 && pushed == NR) idle_streak++;
      else idle_streak = 0;
      if (idle_streak >= 4) begin
        drained = 1;
        break;
      end

      if (have == 0 && pushed < NR && $urandom_range(0, 1) == 1) begin
        pend.modo = 2'($urandom_range(0, 3));
        pend.d    = 4'($urandom_range(0, 15));
        pend.len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
        have = 1;
      end
      cmd_valid = (have == 1) && ($urandom_range(0, 3) != 0);
      cmd_modo = pend.modo; cmd_d = pend.d; cmd_len = 8'(pend.len);
      if (cmd_valid && cmd_ready) begin
        pushed++;
        have = 0;
        if (pend.len > 0) exp_q.push_back(pend);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("rnd_drained", drained, 1);
    check("rnd_pushed", pushed, NR);
    check("rnd_done_cnt", dones, NR);
    check("rnd_abort_cnt", aborts, 0);
    check("rnd_queue_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
